// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with packet locking: one-hot registered grant feeding a
// downstream one-hot mux; the owner holds the grant until its last beat is accepted.
module rr_arbiter_onehot #(
  parameter int unsigned NR = 4,
  parameter int unsigned IW = $clog2(NR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NR-1:0] req,
  input  logic [NR-1:0] in_last,
  output logic [NR-1:0] in_ready,
  output logic [NR-1:0] grant,
  output logic [IW-1:0] grant_idx,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [NR-1:0] grant_nxt;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] winner;
  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          busy;
  logic          done;

  // Wrap-around scan starting at ptr; only indices below NR are visited.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NR; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NR) cand = cand - NR;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  assign done = out_ready && in_last[grant_idx];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = NR'(1) << winner;
          idx_nxt   = winner;
        end
      end
      BUSY: begin
        // Finished owner drops to lowest priority for the next scan.
        if (done) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
          ptr_nxt   = (grant_idx == IW'(NR - 1)) ? '0 : grant_idx + IW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // Handshake outputs are suppressed while rst is high so nothing is accepted in that cycle.
  assign busy      = (state == BUSY) && !rst;
  assign out_valid = busy;
  assign out_last  = busy && in_last[grant_idx];
  assign in_ready  = (busy && out_ready) ? grant : '0;

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Bench for rr_arbiter_onehot: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural owner/pointer model.
module tb_rr_arbiter_onehot;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] in_last = '0;
  logic          out_ready = 1'b0;
  logic [NR-1:0] in_ready;
  logic [NR-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic          out_valid;
  logic          out_last;

  int checks = 0;
  int failures = 0;

  // Model: who owns the output (-1 = nobody) and who has top priority next.
  int m_owner = -1;
  int m_ptr = 0;

  rr_arbiter_onehot #(.NR(NR), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .in_last(in_last), .in_ready(in_ready),
    .grant(grant), .grant_idx(grant_idx), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < int'(NR); k++) begin
      int j;
      j = (p + k) % int'(NR);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
    end else if (out_ready && in_last[m_owner]) begin
      m_ptr   = (m_owner + 1) % int'(NR);
      m_owner = -1;
    end
  end

  // Per-cycle comparison against the model, mid low phase.
  always @(negedge clk) begin
    int e_grant, e_idx, e_valid, e_last, e_ready;
    #2;
    e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_idx   = (m_owner >= 0) ? m_owner : 0;
    e_valid = (m_owner >= 0 && !rst) ? 1 : 0;
    e_last  = (e_valid == 1) ? int'(in_last[m_owner]) : 0;
    e_ready = (e_valid == 1 && out_ready) ? e_grant : 0;
    chk("grant", int'(grant), e_grant);
    chk("grant_idx", int'(grant_idx), e_idx);
    chk("out_valid", int'(out_valid), e_valid);
    chk("out_last", int'(out_last), e_last);
    chk("in_ready", int'(in_ready), e_ready);
  end

  task automatic cyc(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] lst,
                     input logic ordy);
    @(negedge clk);
    rst = r; req = rq; in_last = lst; out_ready = ordy;
    #3;
  endtask

  initial begin
    logic [NR-1:0] exp_rot [5];
    exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
    exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;

    // Reset, then idle
    cyc(1, 4'b0000, 4'b0000, 1'b1);
    chk("rst_in_ready", int'(in_ready), 0);
    cyc(1, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0000, 4'b0000, 1'b1);
      chk("idle_grant", int'(grant), 0);
      chk("idle_valid", int'(out_valid), 0);
    end

    // Rotation: single-beat packets from all ports
    for (int i = 0; i < 10; i++) begin
      cyc(0, 4'b1111, 4'b1111, 1'b1);
      if (i % 2 == 1) begin
        chk("rot_grant", int'(grant), int'(exp_rot[i / 2]));
        chk("rot_idx", int'(grant_idx), (i / 2) % 4);
      end else begin
        chk("rot_gap", int'(grant), 0);
      end
    end

    // Packet lock: port 0 sends 3 beats while port 2 waits
    cyc(1, 4'b0000, 4'b0000, 1'b0);
    cyc(0, 4'b0101, 4'b0000, 1'b1);
    for (int b = 0; b < 3; b++) begin
      cyc(0, 4'b0101, (b == 2) ? 4'b0001 : 4'b0000, 1'b1);
      chk("lock_grant", int'(grant), 1);
      chk("lock_ready", int'(in_ready), 1);
    end
    cyc(0, 4'b0100, 4'b0000, 1'b1);
    chk("lock_gap", int'(grant), 0);
    cyc(0, 4'b0100, 4'b0100, 1'b1);
    chk("lock_next", int'(grant), 4);

    // Wrap-around: ptr is 3 after port 2, so port 0 beats port 1
    cyc(0, 4'b0011, 4'b0000, 1'b1);
    cyc(0, 4'b0011, 4'b0001, 1'b1);
    chk("wrap_grant", int'(grant), 1);

    // Backpressure on port 1's last beat
    cyc(0, 4'b0010, 4'b0010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cyc(0, 4'b0010, 4'b0010, (c == 4));
      chk("bp_grant", int'(grant), 2);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ready", int'(in_ready), (c == 4) ? 2 : 0);
    end
    cyc(0, 4'b0000, 4'b0000, 1'b1);
    chk("bp_idle", int'(out_valid), 0);

    // Reset aborts port 2 mid-packet; ptr returns to 0
    cyc(0, 4'b0100, 4'b0000, 1'b1);
    cyc(0, 4'b0100, 4'b0000, 1'b1);
    chk("mid_grant", int'(grant), 4);
    cyc(1, 4'b0100, 4'b0000, 1'b1);
    chk("mid_rst_ready", int'(in_ready), 0);
    cyc(0, 4'b0110, 4'b0000, 1'b1);
    chk("mid_after_grant", int'(grant), 0);
    chk("mid_after_valid", int'(out_valid), 0);
    cyc(0, 4'b0110, 4'b0010, 1'b1);
    chk("mid_regrant", int'(grant), 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom() % 64) == 0, NR'($urandom()), NR'($urandom()),
          ($urandom() % 4) != 0);
      checks++;
      if (!$onehot0(grant)) begin
        failures++;
        $display("FAIL onehot: got grant %b required one-hot or zero", grant);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
